// File: rtl/wallet_ctrl.sv
// wallet_ctrl: prepaid balance keeper for the washer controller.
// Accumulates top-ups, serves charge requests with an ack/nack handshake
// and publishes blank-suppressed BCD digits of the balance.
// Optional refund path is compiled in when WALLET_REFUND_EN is defined.
//
// Charge handshake: the requester raises chg_req with a stable chg_amt and
// holds it. The request is registered once (req_q), so the FSM acts one edge
// after the edge that first samples chg_req. Exactly one of chg_ack/chg_nack
// pulses for one cycle per accepted request; chg_ack means bal has already
// been reduced. The requester must then drop chg_req; until the registered
// copy of chg_req reads low the FSM stays in WAIT_DROP, so a held request
// is never charged twice.
module wallet_ctrl #(
  parameter int BAL_MAX = 999,
  parameter int AMT0    = 1,
  parameter int AMT1    = 5,
  parameter int AMT2    = 10,
  parameter int AMT3    = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        on,
  input  logic        add_pos,
  input  logic [1:0]  add_sel,
  input  logic        chg_req,
  input  logic [11:0] chg_amt,
  input  logic        refund_pos,
  output logic [11:0] bal,
  output logic        chg_ack,
  output logic        chg_nack,
  output logic        busy,
  output logic        sat,
  output logic [3:0]  d2,
  output logic [3:0]  d1,
  output logic [3:0]  d0,
  output logic [11:0] refund_amt
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECK     = 3'd1;
  localparam logic [2:0] S_DEDUCT    = 3'd2;
  localparam logic [2:0] S_ACK       = 3'd3;
  localparam logic [2:0] S_NACK      = 3'd4;
  localparam logic [2:0] S_WAIT_DROP = 3'd5;

  localparam logic [3:0] BLANK = 4'd11;

  logic [2:0]  state;
  logic        req_q;
  logic [11:0] amt_q;
  logic [11:0] add_amt;
  logic [12:0] add_sum;
  logic        add_clip;
  logic        idle_quiet;
  logic        do_add;
  logic        do_refund;
  logic [11:0] bal_mod;
  logic [3:0]  hund;
  logic [3:0]  tens;
  logic [3:0]  units;

  // Top-up amount selected by add_sel
  always_comb begin
    add_amt = 12'(AMT0);
    case (add_sel)
      2'b00:   add_amt = 12'(AMT0);
      2'b01:   add_amt = 12'(AMT1);
      2'b10:   add_amt = 12'(AMT2);
      default: add_amt = 12'(AMT3);
    endcase
  end

  // 13-bit sum so an overflow past 4095 is still seen as a clip
  assign add_sum  = {1'b0, bal} + {1'b0, add_amt};
  assign add_clip = add_sum > 13'(BAL_MAX);

  // IDLE with no request pending or arriving: a charge beats refund and top-up
  assign idle_quiet = (state == S_IDLE) && on && !req_q && !chg_req;

`ifdef WALLET_REFUND_EN
  assign do_refund = idle_quiet && refund_pos;
  assign do_add    = idle_quiet && add_pos && !refund_pos;

  // Refund captures the whole balance at the edge that zeroes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refund_amt <= '0;
    end else if (do_refund) begin
      refund_amt <= bal;
    end
  end
`else
  logic unused_refund;
  assign unused_refund = refund_pos;
  assign do_refund     = 1'b0;
  assign do_add        = idle_quiet && add_pos;
  assign refund_amt    = '0;
`endif

  // Registered copy of the charge request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 1'b0;
    end else begin
      req_q <= chg_req;
    end
  end

  // Charge FSM; dropping on abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      amt_q <= '0;
    end else if (!on) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_q) begin
            amt_q <= chg_amt;
            state <= S_CHECK;
          end
        end
        S_CHECK:     state <= (bal >= amt_q) ? S_DEDUCT : S_NACK;
        S_DEDUCT:    state <= S_ACK;
        S_ACK:       state <= S_WAIT_DROP;
        S_NACK:      state <= S_WAIT_DROP;
        S_WAIT_DROP: if (!req_q) state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // Balance register and clip pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bal <= '0;
      sat <= 1'b0;
    end else begin
      sat <= 1'b0;
      if (on && state == S_DEDUCT) begin
        bal <= bal - amt_q;
      end else if (do_refund) begin
        bal <= '0;
      end else if (do_add) begin
        bal <= add_clip ? 12'(BAL_MAX) : add_sum[11:0];
        sat <= add_clip;
      end
    end
  end

  assign chg_ack  = (state == S_ACK);
  assign chg_nack = (state == S_NACK);
  assign busy     = (state != S_IDLE);

  // BCD split of the balance (modulo 1000 above 999)
  always_comb begin
    bal_mod = bal % 12'd1000;
    hund    = 4'(bal_mod / 12'd100);
    tens    = 4'((bal_mod / 12'd10) % 12'd10);
    units   = 4'(bal_mod % 12'd10);
  end

  // Display digits, one cycle behind bal, leading zeros blanked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d2 <= BLANK;
      d1 <= BLANK;
      d0 <= 4'd0;
    end else begin
      d2 <= (bal < 12'd100) ? BLANK : hund;
      d1 <= (bal < 12'd10)  ? BLANK : tens;
      d0 <= units;
    end
  end

endmodule

// File: tb/tb_wallet_ctrl.sv
// Bench for wallet_ctrl: directed scenarios plus random top-ups and charges
// against a balance model; responses checked by a scoreboard monitor.
module tb_wallet_ctrl;

  logic        clk;
  logic        rst;
  logic        on;
  logic        add_pos;
  logic [1:0]  add_sel;
  logic        chg_req;
  logic [11:0] chg_amt;
  logic        refund_pos;
  logic [11:0] bal;
  logic        chg_ack;
  logic        chg_nack;
  logic        busy;
  logic        sat;
  logic [3:0]  d2;
  logic [3:0]  d1;
  logic [3:0]  d0;
  logic [11:0] refund_amt;

  wallet_ctrl dut (
    .clk(clk), .rst(rst), .on(on), .add_pos(add_pos), .add_sel(add_sel),
    .chg_req(chg_req), .chg_amt(chg_amt), .refund_pos(refund_pos),
    .bal(bal), .chg_ack(chg_ack), .chg_nack(chg_nack), .busy(busy),
    .sat(sat), .d2(d2), .d1(d1), .d0(d0), .refund_amt(refund_amt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int model_bal = 0;
  int exp_sat = 0;
  int sat_seen = 0;
  int amt_tab[4] = '{1, 5, 10, 50};
  logic [12:0] exp_q[$];   // {is_ack, balance after response}

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && (chg_ack || chg_nack)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {30'd0, chg_ack, chg_nack}, 0);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("resp_kind_ack", chg_ack, e[12]);
        chk("resp_kind_nack", chg_nack, !e[12]);
        chk("resp_bal", bal, e[11:0]);
      end
    end
    if (!rst && sat) sat_seen++;
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check_digits(input string name);
    int e2, e1, e0;
    e2 = (model_bal >= 100) ? (model_bal / 100) % 10 : 11;
    e1 = (model_bal >= 10) ? (model_bal / 10) % 10 : 11;
    e0 = model_bal % 10;
    chk({name, "_d2"}, d2, e2);
    chk({name, "_d1"}, d1, e1);
    chk({name, "_d0"}, d0, e0);
  endtask

  task automatic do_add(input int sel);
    int sum;
    add_sel = 2'(sel);
    add_pos = 1'b1;
    tick(1);
    add_pos = 1'b0;
    sum = model_bal + amt_tab[sel];
    if (sum > 999) begin
      sum = 999;
      exp_sat++;
    end
    model_bal = sum;
    chk("add_bal", bal, model_bal);
    tick(1);
  endtask

  task automatic do_charge(input int amt, input int hold);
    int old;
    bit exp_ack;
    bit got;
    int lat;
    old = model_bal;
    exp_ack = (model_bal >= amt);
    if (exp_ack) model_bal = model_bal - amt;
    exp_q.push_back({exp_ack, 12'(model_bal)});
    chg_amt = 12'(amt);
    chg_req = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 2) begin
        chk("busy_in_check", busy, 1);
        chg_amt = 12'($urandom);
      end
      if (exp_ack && k == 3) chk("bal_before_commit", bal, old);
      if (chg_ack || chg_nack) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    chk("resp_seen", got, 1);
    if (got) chk("resp_latency", lat, exp_ack ? 4 : 3);
    else if (exp_q.size() > 0) void'(exp_q.pop_back());
    tick(hold);
    chg_req = 1'b0;
    tick(3);
    chk("idle_after_drop", busy, 0);
    chk("bal_after_charge", bal, model_bal);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; on = 1'b0; add_pos = 1'b0; add_sel = 2'd0;
    chg_req = 1'b0; chg_amt = '0; refund_pos = 1'b0;
    tick(2);
    chk("rst_bal", bal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", chg_ack, 0);
    chk("rst_nack", chg_nack, 0);
    chk("rst_sat", sat, 0);
    chk("rst_refund", refund_amt, 0);
    check_digits("rst");
    rst = 1'b0;
    on = 1'b1;
    tick(2);

    // Top-ups to 155
    do_add(3); do_add(3); do_add(3); do_add(1);
    chk("bal_155", bal, 155);
    check_digits("dig_155");
    chk("no_sat_yet", sat_seen, 0);

    // Accepted charge with a held request
    do_charge(120, 5);
    chk("bal_35", bal, 35);
    chk("d2_blank", d2, 11);
    check_digits("dig_35");

    // Insufficient balance
    do_charge(40, 0);
    chk("bal_nack", bal, 35);

    // Power drop one cycle after the request is sampled
    chg_amt = 12'd20; chg_req = 1'b1;
    tick(1);
    on = 1'b0;
    tick(3);
    chk("abort_idle_busy", busy, 0);
    chg_req = 1'b0;
    tick(2);
    on = 1'b1;
    tick(2);
    chk("abort_idle_bal", bal, model_bal);

    // Power drop while in CHECK
    chg_amt = 12'd10; chg_req = 1'b1;
    tick(2);
    chk("abort_chk_busy_hi", busy, 1);
    on = 1'b0;
    tick(1);
    chk("abort_chk_busy_lo", busy, 0);
    chg_req = 1'b0;
    tick(2);
    on = 1'b1;
    tick(2);
    chk("abort_chk_bal", bal, model_bal);

    // Refund pulse
    refund_pos = 1'b1;
    tick(1);
    refund_pos = 1'b0;
`ifdef WALLET_REFUND_EN
    chk("refund_amt", refund_amt, model_bal);
    model_bal = 0;
`else
    chk("refund_amt", refund_amt, 0);
`endif
    chk("refund_bal", bal, model_bal);
    tick(1);

    // Fill to 980, then clip twice
    while (model_bal + 50 <= 980) do_add(3);
    while (model_bal + 10 <= 980) do_add(2);
    while (model_bal + 5 <= 980) do_add(1);
    while (model_bal + 1 <= 980) do_add(0);
    chk("bal_980", bal, 980);
    chk("sat_before_clip", sat_seen, exp_sat);
    do_add(3);
    chk("bal_max", bal, 999);
    do_add(0);
    chk("bal_max_again", bal, 999);
    chk("sat_two_clips", sat_seen, exp_sat);
    check_digits("dig_999");

    // Asynchronous reset while in DEDUCT
    chg_amt = 12'd100; chg_req = 1'b1;
    tick(3);
    chk("deduct_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_bal", bal, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_d2", d2, 11);
    chg_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_bal = 0;
    tick(2);
    chk("post_rst_bal", bal, 0);
    check_digits("dig_rst");

    // Random top-ups and charges
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 5) begin
        do_add($urandom_range(0, 3));
      end else begin
        int amt;
        int top;
        top = (model_bal + 40 > 4095) ? 4095 : model_bal + 40;
        amt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, top);
        do_charge(amt, $urandom_range(0, 3));
      end
      check_digits("rand_dig");
    end

    tick(2);
    chk("final_sat_count", sat_seen, exp_sat);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
